jt89_psg: RTL

- Parametrised SN76489-family PSG core: three square-wave tone channels and one noise channel.
- Generalised over tone-counter width, noise LFSR width and taps, prescaler ratio and output width.
- Adds a modelled READY wait-state handshake and SMS-style noise-control data-byte writes.
- Sits under the system bus / CPU interface; the signed `sound` output feeds the board mixer.

---
 rtl/jt89_psg_if.sv | 9 +
 rtl/jt89_psg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jt89_psg_if.sv
// CPU-side write port of the jt89 PSG: active-low strobe, data byte and READY.
interface jt89_psg_if;
  logic       wr_n;
  logic [7:0] din;
  logic       ready;

  modport master (output wr_n, din, input ready);
  modport slave  (input wr_n, din, output ready);
endinterface

// File: rtl/jt89_psg.sv
// SN76489-family PSG: three square-wave tones plus LFSR noise, signed mono mix.
// Optional Game Gear stereo panning is enabled with `define JT89_STEREO_EN.
module jt89_psg #(
  parameter int          TW   = 10,
  parameter int          NW   = 16,
  parameter int unsigned NTAP = 16'h0009,
  parameter int          PDIV = 16,
  parameter int          WAIT = 32,
  parameter int          OW   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  jt89_psg_if.slave            bus,
`ifdef JT89_STEREO_EN
  input  logic                 gg_wr,
  output logic signed [OW-1:0] left,
  output logic signed [OW-1:0] right,
`endif
  output logic signed [OW-1:0] sound
);
  localparam int            PW   = $clog2(PDIV);
  localparam int            WCW  = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [NW-1:0] SEED = {1'b1, {(NW-1){1'b0}}};
  localparam logic [NW-1:0] TAPM = NTAP[NW-1:0];
  localparam logic [63:0]   AMAX = (64'd1 << (OW - 3)) - 64'd1;

  logic [PW-1:0]      r_pre;
  logic               r_cen_d;
  logic               r_wr_n_d;
  logic               r_ready;
  logic [WCW-1:0]     r_wcnt;
  logic [2:0]         r_lat;
  logic [2:0][TW-1:0] r_per;
  logic [2:0][TW-1:0] r_cnt;
  logic [2:0]         r_tone;
  logic [3:0][3:0]    r_vol;
  logic [2:0]         r_nctl;
  logic [5:0]         r_ncnt;
  logic [NW-1:0]      r_lfsr;

  logic               w_cen;
  logic               w_wr;
  logic [2:0]         w_reg;
  logic               w_nwr;
  logic [2:0]         w_rld;
  logic [2:0]         w_tone_nx;
  logic               w_nsh;
  logic               w_fb;
  logic [3:0]         w_out;
  logic [3:0][OW-1:0] w_term;
  logic signed [OW-1:0] w_sum;

  // 2 dB per step; fractions of full scale in Q16, 0xF is silence.
  function automatic logic [OW-1:0] f_amp(input logic [3:0] v);
    logic [16:0] fr;
    logic [63:0] p;
    case (v)
      4'd0:    fr = 17'd65536;
      4'd1:    fr = 17'd52057;
      4'd2:    fr = 17'd41350;
      4'd3:    fr = 17'd32846;
      4'd4:    fr = 17'd26090;
      4'd5:    fr = 17'd20724;
      4'd6:    fr = 17'd16462;
      4'd7:    fr = 17'd13076;
      4'd8:    fr = 17'd10387;
      4'd9:    fr = 17'd8250;
      4'd10:   fr = 17'd6554;
      4'd11:   fr = 17'd5206;
      4'd12:   fr = 17'd4135;
      4'd13:   fr = 17'd3285;
      4'd14:   fr = 17'd2609;
      default: fr = 17'd0;
    endcase
    p = AMAX * {47'd0, fr};
    return OW'(p >> 16);
  endfunction

  assign w_cen     = clk_en & (&r_pre);
  assign w_wr      = r_wr_n_d & ~bus.wr_n & r_ready;
  assign w_reg     = bus.din[7] ? bus.din[6:4] : r_lat;
  assign w_nwr     = w_wr & (w_reg == 3'b110);
  assign bus.ready = r_ready;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pre    <= '0;
      r_cen_d  <= 1'b0;
      r_wr_n_d <= 1'b1;
    end else begin
      if (clk_en) r_pre <= r_pre + 1'b1;
      r_cen_d  <= w_cen;
      r_wr_n_d <= bus.wr_n;
    end

  // READY drops the clk after an accepted write and counts WAIT chip ticks.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ready <= 1'b1;
      r_wcnt  <= '0;
    end else if (w_wr && WAIT != 0) begin
      r_ready <= 1'b0;
      r_wcnt  <= WCW'(WAIT);
    end else if (!r_ready && clk_en) begin
      if (r_wcnt <= WCW'(1)) begin
        r_ready <= 1'b1;
        r_wcnt  <= '0;
      end else begin
        r_wcnt <= r_wcnt - 1'b1;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_lat  <= '0;
      r_per  <= '0;
      r_vol  <= '1;
      r_nctl <= 3'b100;
    end else if (w_wr) begin
      if (bus.din[7]) r_lat <= bus.din[6:4];
      if (w_reg[0])                r_vol[w_reg[2:1]] <= bus.din[3:0];
      else if (w_reg == 3'b110)    r_nctl <= bus.din[2:0];
      else if (bus.din[7])         r_per[w_reg[2:1]][3:0] <= bus.din[3:0];
      else                         r_per[w_reg[2:1]][TW-1:4] <= bus.din[TW-5:0];
    end

  // Reload when the counter would reach zero; periods 0/1 pin the output high.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_rld[i]     = r_cnt[i] <= TW'(1);
      w_tone_nx[i] = r_tone[i];
      if (w_rld[i]) w_tone_nx[i] = (r_per[i] <= TW'(1)) ? 1'b1 : ~r_tone[i];
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt  <= '0;
      r_tone <= '1;
    end else if (w_cen) begin
      for (int i = 0; i < 3; i++)
        r_cnt[i] <= w_rld[i] ? r_per[i] : r_cnt[i] - 1'b1;
      r_tone <= w_tone_nx;
    end

  always_comb begin
    case (r_nctl[1:0])
      2'b00:   w_nsh = w_cen & (&r_ncnt[3:0]);
      2'b01:   w_nsh = w_cen & (&r_ncnt[4:0]);
      2'b10:   w_nsh = w_cen & (&r_ncnt);
      default: w_nsh = w_cen & ~r_tone[2] & w_tone_nx[2];
    endcase
    w_fb = r_nctl[2] ? ^(r_lfsr & TAPM) : r_lfsr[0];
  end

  // Rate divider restarts on every control write so the first shift is a full period away.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ncnt <= '0;
      r_lfsr <= SEED;
    end else if (w_nwr) begin
      r_ncnt <= '0;
      r_lfsr <= SEED;
    end else begin
      if (w_cen) r_ncnt <= r_ncnt + 1'b1;
      if (w_nsh) r_lfsr <= (r_lfsr == '0) ? SEED : {w_fb, r_lfsr[NW-1:1]};
    end

  always_comb begin
    w_out = {r_lfsr[0], r_tone};
    w_sum = '0;
    for (int i = 0; i < 4; i++) begin
      w_term[i] = w_out[i] ? f_amp(r_vol[i]) : -f_amp(r_vol[i]);
      w_sum     = w_sum + $signed(w_term[i]);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)          sound <= '0;
    else if (r_cen_d) sound <= w_sum;

`ifdef JT89_STEREO_EN
  logic [7:0]           r_pan;
  logic signed [OW-1:0] w_lsum;
  logic signed [OW-1:0] w_rsum;

  always_comb begin
    w_lsum = '0;
    w_rsum = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_pan[4+i]) w_lsum = w_lsum + $signed(w_term[i]);
      if (r_pan[i])   w_rsum = w_rsum + $signed(w_term[i]);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pan <= 8'hFF;
      left  <= '0;
      right <= '0;
    end else begin
      if (gg_wr) r_pan <= bus.din;
      if (r_cen_d) begin
        left  <= w_lsum;
        right <= w_rsum;
      end
    end
`endif

endmodule
